// File: rtl/i2c_target_regfile.sv
// I2C target with a 256 x 8 register file. It serves pointer writes, data writes and
// sequential reads over the bus, and gives fabric logic a host port into the same registers.
`timescale 1ns/1ps
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR    = 7'h77,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       bus_wr_valid,
    output logic [7:0] bus_wr_addr,
    output logic [7:0] bus_wr_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT
    } state_e;

    // Pin conditioning: synchronizers idle high, like the released bus.
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise_q, scl_fall_q, start_q, stop_q, sda_bit_q;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_bit_q  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
            scl_rise_q <= scl_s & ~scl_hist_q;
            scl_fall_q <= ~scl_s & scl_hist_q;
            start_q    <= scl_s & scl_hist_q & sda_hist_q & ~sda_s;
            stop_q     <= scl_s & scl_hist_q & ~sda_hist_q & sda_s;
            sda_bit_q  <= sda_s;
        end
    end

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] ptr_q, ptr_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       bus_wr_valid_q, bus_we;
    logic [7:0] bus_wr_addr_q, bus_wr_addr_d;
    logic [7:0] bus_wr_data_q, bus_wr_data_d;
    logic [7:0] host_rdata_q;
    logic [7:0] regs_q [256];
    logic [7:0] rd_byte;

    assign rd_byte = regs_q[ptr_q];

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path infers a latch.
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        ptr_d         = ptr_q;
        sda_oe_d      = sda_oe_q;
        busy_d        = busy_q;
        bus_we        = 1'b0;
        bus_wr_addr_d = bus_wr_addr_q;
        bus_wr_data_d = bus_wr_data_q;

        if (start_q) begin
            state_d   = ST_ADDR;
            busy_d    = 1'b1;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (stop_q) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise_q) begin
                        shreg_d   = {shreg_q[6:0], sda_bit_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_q && bit_cnt_q == 4'd8) begin
                        if (state_q == ST_ADDR) begin
                            if (shreg_q[7:1] == DEV_ADDR) begin
                                sda_oe_d = 1'b1;
                                state_d  = ST_ADDR_ACK;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = ST_WAIT;
                            end
                        end else if (state_q == ST_PTR) begin
                            sda_oe_d = 1'b1;
                            ptr_d    = shreg_q;
                            state_d  = ST_PTR_ACK;
                        end else begin
                            bus_we        = 1'b1;
                            bus_wr_addr_d = ptr_q;
                            bus_wr_data_d = shreg_q;
                            ptr_d         = ptr_q + 8'd1;
                            sda_oe_d      = 1'b1;
                            state_d       = ST_WDATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_q) begin
                        bit_cnt_d = 4'd0;
                        // The address byte is still in shreg; its LSB is the R/W flag.
                        if (shreg_q[0]) begin
                            shreg_d  = rd_byte;
                            ptr_d    = ptr_q + 8'd1;
                            sda_oe_d = ~rd_byte[7];
                            state_d  = ST_RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_PTR;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall_q) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise_q) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_q) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RDATA_ACK;
                        end else begin
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            sda_oe_d = ~shreg_q[6];
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise_q && sda_bit_q) begin
                        state_d = ST_WAIT;
                    end else if (scl_fall_q) begin
                        shreg_d   = rd_byte;
                        ptr_d     = ptr_q + 8'd1;
                        sda_oe_d  = ~rd_byte[7];
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RDATA;
                    end
                end
                ST_WAIT: sda_oe_d = 1'b0;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= 4'd0;
            shreg_q        <= 8'd0;
            ptr_q          <= 8'd0;
            sda_oe_q       <= 1'b0;
            busy_q         <= 1'b0;
            bus_wr_valid_q <= 1'b0;
            bus_wr_addr_q  <= 8'd0;
            bus_wr_data_q  <= 8'd0;
            host_rdata_q   <= 8'd0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shreg_q        <= shreg_d;
            ptr_q          <= ptr_d;
            sda_oe_q       <= sda_oe_d;
            busy_q         <= busy_d;
            bus_wr_valid_q <= bus_we;
            bus_wr_addr_q  <= bus_wr_addr_d;
            bus_wr_data_q  <= bus_wr_data_d;
            host_rdata_q   <= regs_q[host_addr];
        end
    end

    // NOTE: the register file has no reset; contents stay undefined until host or bus writes them.
    always_ff @(posedge clk) begin
        if (host_we && !(bus_we && host_addr == ptr_q)) begin
            regs_q[host_addr] <= host_wdata;
        end
        if (bus_we) begin
            regs_q[ptr_q] <= shreg_q;
        end
    end

    assign sda_oe       = sda_oe_q;
    assign busy         = busy_q;
    assign bus_wr_valid = bus_wr_valid_q;
    assign bus_wr_addr  = bus_wr_addr_q;
    assign bus_wr_data  = bus_wr_data_q;
    assign host_rdata   = host_rdata_q;

endmodule
